// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load-store controller.
// Optional misaligned split is enabled with LSU_MISALIGN_SPLIT_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_BAD
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    WR0,
    WR1,
    RESP
  } state_e;

  localparam logic [31:0] MEM_TOP_ADDR_DFLT = 32'h0000_07FF;

  function automatic logic [2:0] nbytes(size_e sz);
    case (sz)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: load extraction with sign/zero extension
// and read-modify-write merge over a two-word window.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_buf0,
  input  logic [31:0] i_buf1,
  input  logic [1:0]  i_off,
  input  size_e       i_size,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_val,
  output logic [63:0] o_st_word
);

  logic [63:0] win;
  logic [63:0] sh;
  logic [63:0] data;
  logic [63:0] bitmask;
  logic [7:0]  lanes;

  assign win  = {i_buf1, i_buf0};
  assign sh   = win >> {i_off, 3'b000};
  assign data = {32'b0, i_wdata} << {i_off, 3'b000};

  always_comb begin
    o_ld_val = sh[31:0];
    case (i_size)
      SZ_B: o_ld_val = i_uns ? {24'b0, sh[7:0]}
                             : {{24{sh[7]}}, sh[7:0]};
      SZ_H: o_ld_val = i_uns ? {16'b0, sh[15:0]}
                             : {{16{sh[15]}}, sh[15:0]};
      default: o_ld_val = sh[31:0];
    endcase
  end

  always_comb begin
    case (i_size)
      SZ_B:    lanes = 8'h01 << i_off;
      SZ_H:    lanes = 8'h03 << i_off;
      default: lanes = 8'h0F << i_off;
    endcase
    bitmask = '0;
    for (int i = 0; i < 8; i++) begin
      bitmask[8*i +: 8] = {8{lanes[i]}};
    end
  end

  assign o_st_word = (win & ~bitmask) | (data & bitmask);

endmodule

// File: rtl/lsu_ctrl.sv
// Load-store initiator: byte/half/word requests to word-only memory.
// Define LSU_MISALIGN_SPLIT_EN to split accesses spanning two words.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] MEM_TOP_ADDR = MEM_TOP_ADDR_DFLT,
  parameter int          ADDR_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  output logic              o_mem_u,
  input  logic [31:0]       i_mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  size_e             size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf0_q, buf0_d;
  logic [31:0]       buf1_w;

  size_e             req_size;
  logic [2:0]        req_nb;
  logic              req_span;
  logic [ADDR_W:0]   req_last;
  logic              req_err;
  logic [ADDR_W-1:0] addr0;
  logic [31:0]       ld_val;
  logic [63:0]       st_word;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]       buf1_q, buf1_d;
  logic              span_q, span_d;
  assign buf1_w = buf1_q;
`else
  logic              unused_hi;
  assign buf1_w    = '0;
  assign unused_hi = ^st_word[63:32];
`endif

  assign req_size = size_e'(i_req_size);
  assign req_nb   = nbytes(req_size);
  assign req_span = ({1'b0, i_req_addr[1:0]} + req_nb) > 3'd4;
  // 33-bit sum so an address wrap past 2^32 is still caught
  assign req_last = {1'b0, i_req_addr}
                  + {{(ADDR_W-2){1'b0}}, req_nb}
                  - {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    req_err = (req_size == SZ_BAD)
            | (req_last > {1'b0, MEM_TOP_ADDR});
`ifndef LSU_MISALIGN_SPLIT_EN
    req_err = req_err | req_span;
`endif
  end

  assign addr0   = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_u = 1'b0;

  lsu_align u_align (
    .i_buf0    (buf0_q),
    .i_buf1    (buf1_w),
    .i_off     (addr_q[1:0]),
    .i_size    (size_q),
    .i_uns     (uns_q),
    .i_wdata   (wdata_q),
    .o_ld_val  (ld_val),
    .o_st_word (st_word)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    uns_d       = uns_q;
    err_d       = err_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf0_d      = buf0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    buf1_d      = buf1_q;
    span_d      = span_q;
`endif
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = '0;
    o_rsp_err   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = 4'b0000;
    o_mem_wren  = 1'b0;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          we_d    = i_req_we;
          uns_d   = i_req_unsigned;
          size_d  = req_size;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          err_d   = req_err;
`ifdef LSU_MISALIGN_SPLIT_EN
          span_d  = req_span;
`endif
          if (req_err) begin
            state_d = RESP;
          end else if (i_req_we && req_size == SZ_W
                       && i_req_addr[1:0] == 2'b00) begin
            state_d = WR0;
          end else begin
            state_d = RD0;
          end
        end
      end
      RD0: begin
        o_mem_addr  = addr0;
        o_mem_bmask = 4'b1111;
        buf0_d      = i_mem_rdata;
        state_d     = we_q ? WR0 : RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (span_q) state_d = RD1;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      RD1: begin
        o_mem_addr  = addr0 + 4;
        o_mem_bmask = 4'b1111;
        buf1_d      = i_mem_rdata;
        state_d     = we_q ? WR0 : RESP;
      end
      WR1: begin
        o_mem_addr  = addr0 + 4;
        o_mem_bmask = 4'b1111;
        o_mem_wren  = 1'b1;
        o_mem_wdata = st_word[63:32];
        state_d     = RESP;
      end
`endif
      WR0: begin
        o_mem_addr  = addr0;
        o_mem_bmask = 4'b1111;
        o_mem_wren  = 1'b1;
        o_mem_wdata = st_word[31:0];
        state_d     = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (span_q) state_d = WR1;
`endif
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_q;
        o_rsp_rdata = (err_q || we_q) ? '0 : ld_val;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      buf0_q  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      buf1_q  <= '0;
      span_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf0_q  <= buf0_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      buf1_q  <= buf1_d;
      span_q  <= span_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: vector table with a response scoreboard,
// plus a reset-during-write sequence.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_uns;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_wren;
  logic        mem_u;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:511];
  logic        bd_we;
  logic [8:0]  bd_idx;
  logic [31:0] bd_val;

  int n_chk;
  int n_pass;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    int          nacc;
    logic        ck;
    logic [31:0] ck_addr;
    logic [31:0] ck_val;
  } vec_t;

  vec_t vt[$];
  vec_t exp_q[$];

  lsu_ctrl dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_size     (req_size),
    .i_req_unsigned (req_uns),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_bmask    (mem_bmask),
    .o_mem_wren     (mem_wren),
    .o_mem_u        (mem_u),
    .i_mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[10:2]];

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr[10:2]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_val;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic poke(logic [31:0] a, logic [31:0] v);
    @(negedge clk);
    bd_we  = 1'b1;
    bd_idx = a[10:2];
    bd_val = v;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  function automatic vec_t mk(logic we, logic [31:0] a,
                              logic [31:0] wd, logic [1:0] sz,
                              logic u, logic [31:0] rd, logic er,
                              int lat, int nwr, int nacc, logic ck,
                              logic [31:0] cka, logic [31:0] ckv);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.size = sz; v.uns = u;
    v.rdata = rd; v.err = er; v.lat = lat; v.nwr = nwr;
    v.nacc = nacc; v.ck = ck; v.ck_addr = cka; v.ck_val = ckv;
    return v;
  endfunction

  task automatic drive(vec_t v);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_size  = v.size;
    req_uns   = v.uns;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_vec(int idx, vec_t v);
    vec_t e;
    int   nwr;
    int   nacc;
    int   lat;
    bit   got;
    logic [31:0] rd;
    logic        er;
    nwr = 0; nacc = 0; lat = 0; got = 1'b0; rd = '0; er = 1'b0;
    exp_q.push_back(v);
    drive(v);
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (mem_bmask != 4'b0000) nacc++;
      if (mem_wren) nwr++;
      if (rsp_valid) begin
        got = 1'b1; lat = c; rd = rsp_rdata; er = rsp_err;
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      n_chk++;
      $display("FAIL v%0d timeout: got no response expected one", idx);
      return;
    end
    chk($sformatf("v%0d rdata", idx), rd, e.rdata);
    chk($sformatf("v%0d err", idx), 32'(er), 32'(e.err));
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(e.lat));
    chk($sformatf("v%0d wren_cycles", idx), 32'(nwr), 32'(e.nwr));
    chk($sformatf("v%0d access_cycles", idx), 32'(nacc), 32'(e.nacc));
    @(negedge clk);
    chk($sformatf("v%0d idle_after", idx),
        {29'b0, rsp_valid, req_ready, rsp_err}, 32'b010);
    if (e.ck)
      chk($sformatf("v%0d mem[%h]", idx, e.ck_addr),
          mem[e.ck_addr[10:2]], e.ck_val);
  endtask

  initial begin
    bit saw_rsp;
    n_chk = 0; n_pass = 0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = '0; req_uns = 1'b0;
    bd_we = 1'b0; bd_idx = '0; bd_val = '0;
    rst_n = 1'b0;

    vt.push_back(mk(0, 'h12, 0, 0, 0, 'hFFFFFF99, 0, 2, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 'h12, 0, 0, 1, 'h00000099, 0, 2, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 'h10, 0, 1, 0, 'hFFFFAABB, 0, 2, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 'h12, 0, 1, 1, 'h00008899, 0, 2, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 'h10, 0, 2, 0, 'h8899AABB, 0, 2, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 'h21, 'h1234, 1, 0, 0, 0, 3, 1, 2,
                    1, 'h20, 'hFF1234FF));
    vt.push_back(mk(1, 'h40, 'hCAFEBABE, 2, 0, 0, 0, 2, 1, 1,
                    1, 'h40, 'hCAFEBABE));
    vt.push_back(mk(1, 'h43, 'hFFFFFFA5, 0, 0, 0, 0, 3, 1, 2,
                    1, 'h40, 'hA5FEBABE));
    vt.push_back(mk(0, 'h43, 0, 0, 0, 'hFFFFFFA5, 0, 2, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 'h7FE, 0, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 'h800, 'h5A, 0, 0, 0, 1, 1, 0, 0,
                    1, 'h7FC, 'h11223344));
    vt.push_back(mk(0, 'h10, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 'hFFFFFFFE, 0, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 'h7FC, 0, 2, 0, 'h11223344, 0, 2, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 'h7FF, 'h5A, 0, 0, 0, 0, 3, 1, 2,
                    1, 'h7FC, 'h5A223344));
    vt.push_back(mk(1, 'h7FE, 'hBEEF, 1, 0, 0, 0, 3, 1, 2,
                    1, 'h7FC, 'hBEEF3344));
    vt.push_back(mk(0, 'h7FF, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
`ifdef LSU_MISALIGN_SPLIT_EN
    vt.push_back(mk(0, 'h32, 0, 2, 0, 'h66554433, 0, 3, 0, 2, 0, 0, 0));
    vt.push_back(mk(1, 'h36, 'hA1B2C3D4, 2, 0, 0, 0, 5, 2, 4,
                    1, 'h34, 'hC3D46655));
    vt.push_back(mk(0, 'h38, 0, 2, 0, 'h0000A1B2, 0, 2, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 'h33, 0, 1, 0, 'h00005544, 0, 3, 0, 2, 0, 0, 0));
`else
    vt.push_back(mk(0, 'h32, 0, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 'h36, 'hA1B2C3D4, 2, 0, 0, 1, 1, 0, 0,
                    1, 'h34, 'h88776655));
    vt.push_back(mk(0, 'h38, 0, 2, 0, 'h00000000, 0, 2, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 'h33, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
`endif

    #2;
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    chk("reset rdata", rsp_rdata, 32'd0);
    chk("reset mem_ctl", {26'b0, mem_bmask, mem_wren, mem_u}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);

    poke('h10, 'h8899AABB);
    poke('h20, 'hFFFFFFFF);
    poke('h30, 'h44332211);
    poke('h34, 'h88776655);
    poke('h38, 'h00000000);
    poke('h50, 'h01020304);
    poke('h7FC, 'h11223344);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(i, vt[i]);

    drive(mk(1, 'h50, 'hDEADBEEF, 2, 0, 0, 0, 2, 1, 1, 0, 0, 0));
    @(negedge clk);
    chk("rst wr0 reached", 32'(mem_wren), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst wren dropped", 32'(mem_wren), 32'd0);
    chk("rst ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_rsp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("rst no rsp", 32'(saw_rsp), 32'd0);
    chk("rst ready after", 32'(req_ready), 32'd1);
    chk("rst mem kept", mem['h50 >> 2], 32'h01020304);
    run_vec(99, mk(0, 'h50, 0, 2, 0, 'h01020304, 0, 2, 0, 1, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
